// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared types and defaults for the BT-pipe transfer scheduler.
package pipe_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_RECOV = 3'd1,
    S_IDLE  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int unsigned DEF_BLOCK_WORDS = 128;
  localparam int unsigned DEF_IN_DEPTH    = 1024;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_blk_counter.sv
// Word counter with saturating block counter for one pipe direction.
module pipe_blk_counter #(
  parameter int unsigned WORD_W        = 7,
  parameter int unsigned BLK_W         = 16,
  parameter bit          COUNT_PARTIAL = 1'b0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [BLK_W-1:0] limit_i,
  output logic [BLK_W-1:0] blocks_o,
  output logic             more_o,
  output logic             at_limit_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              wrap;
  logic              partial;

  always_comb begin
    wrap   = inc_i && (word_q == '1);
    word_d = inc_i ? word_q + 1'b1 : word_q;
    blk_d  = blk_q;
    if (wrap && (blk_q != '1)) blk_d = blk_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      word_q <= '0;
      blk_q  <= '0;
    end else begin
      word_q <= word_d;
      blk_q  <= blk_d;
    end
  end

  // A block already in flight counts against the limit when COUNT_PARTIAL is set.
  assign partial    = COUNT_PARTIAL && (word_q != '0);
  assign more_o     = ({1'b0, blk_q} + (BLK_W+1)'(partial)) < {1'b0, limit_i};
  assign at_limit_o = (blk_q == limit_i);
  assign blocks_o   = blk_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Transfer scheduler: FIFO reset sequencing, block-ready throttling, block counting.
module pipe_flow_ctrl
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned IN_DEPTH    = DEF_IN_DEPTH,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned RST_HOLD    = 8,
  parameter int unsigned RST_RECOVER = 32,
  parameter int unsigned BLK_W       = 16
) (
  input  logic             okClk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic [CNT_W-1:0] in_wr_count,
  input  logic [CNT_W-1:0] out_rd_count,
  input  logic             pi_write,
  input  logic             po_read,
  output logic             fifo_rst,
  output logic             pipe_in_ready,
  output logic             pipe_out_ready,
  output logic             engine_en,
  output logic             busy,
  output logic             done,
  output logic [BLK_W-1:0] blocks_in,
  output logic [BLK_W-1:0] blocks_out,
  output logic             proto_err
);

  localparam int unsigned    WORD_W      = clog2(BLOCK_WORDS);
  localparam int unsigned    TMR_MAX     = (RST_HOLD > RST_RECOVER) ? RST_HOLD : RST_RECOVER;
  localparam int unsigned    TMR_W       = clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(RST_HOLD - 1);
  localparam logic [TMR_W-1:0] RECOV_LAST = TMR_W'(RST_RECOVER - 1);
  localparam logic [CNT_W:0] IN_ROOM_MAX = (CNT_W+1)'(IN_DEPTH - BLOCK_WORDS);
  localparam logic [CNT_W:0] OUT_BLK_MIN = (CNT_W+1)'(BLOCK_WORDS);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [BLK_W-1:0] num_q, num_d;
  logic             proto_err_q, proto_err_d;
  logic             fifo_rst_q, fifo_rst_d;
  logic             pin_rdy_q, pin_rdy_d;
  logic             pout_rdy_q, pout_rdy_d;
  logic             engine_en_q, busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_run, moving, start_acc, cnt_clr;
  logic             inc_in, inc_out;
  logic             in_more, in_at_limit, out_more, out_at_limit;

  assign is_run    = (state_q == S_RUN);
  assign moving    = is_run || (state_q == S_DRAIN);
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cnt_clr   = rst || start_acc;
  assign inc_in    = pi_write && is_run;
  assign inc_out   = po_read && moving;

  pipe_blk_counter #(
    .WORD_W        (WORD_W),
    .BLK_W         (BLK_W),
    .COUNT_PARTIAL (1'b1)
  ) u_in_cnt (
    .clk_i      (okClk),
    .clr_i      (cnt_clr),
    .inc_i      (inc_in),
    .limit_i    (num_q),
    .blocks_o   (blocks_in),
    .more_o     (in_more),
    .at_limit_o (in_at_limit)
  );

  pipe_blk_counter #(
    .WORD_W        (WORD_W),
    .BLK_W         (BLK_W),
    .COUNT_PARTIAL (1'b0)
  ) u_out_cnt (
    .clk_i      (okClk),
    .clr_i      (cnt_clr),
    .inc_i      (inc_out),
    .limit_i    (num_q),
    .blocks_o   (blocks_out),
    .more_o     (out_more),
    .at_limit_o (out_at_limit)
  );

  always_ff @(posedge okClk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      timer_q     <= '0;
      num_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      num_q       <= num_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    num_d   = num_q;
    case (state_q)
      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_RECOV;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RECOV: begin
        if (timer_q == RECOV_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d   = num_blocks;
          state_d = (num_blocks == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (in_at_limit) state_d = S_DRAIN;
      S_DRAIN: if (out_at_limit) state_d = S_DONE;
      default: begin
        state_d = S_HOLD;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    proto_err_d = proto_err_q
                | (pi_write && (!is_run || in_at_limit))
                | (po_read && (!moving || (out_rd_count == '0)));
  end

  // Mode outputs decode the next state so the registered copies track state_q exactly.
  always_comb begin
    fifo_rst_d = (state_d == S_HOLD);
    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
    pin_rdy_d  = is_run && ({1'b0, in_wr_count} <= IN_ROOM_MAX) && in_more;
    pout_rdy_d = moving && ({1'b0, out_rd_count} >= OUT_BLK_MIN) && out_more;
  end

  always_ff @(posedge okClk) begin
    if (rst) begin
      fifo_rst_q  <= 1'b1;
      pin_rdy_q   <= 1'b0;
      pout_rdy_q  <= 1'b0;
      engine_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fifo_rst_q  <= fifo_rst_d;
      pin_rdy_q   <= pin_rdy_d;
      pout_rdy_q  <= pout_rdy_d;
      engine_en_q <= busy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fifo_rst       = fifo_rst_q;
  assign pipe_in_ready  = pin_rdy_q;
  assign pipe_out_ready = pout_rdy_q;
  assign engine_en      = engine_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: directed scenarios plus randomized runs against a word-count model.
module tb_pipe_flow_ctrl;

  localparam int BW          = 128;
  localparam int ROOM_MAX    = 1024 - 128;
  localparam int RST_HOLD    = 8;
  localparam int RST_RECOVER = 32;
  localparam int BLK_MAX     = 65535;

  logic        okClk = 1'b0;
  logic        rst, start, pi_write, po_read;
  logic [15:0] num_blocks;
  logic [9:0]  in_wr_count, out_rd_count;
  logic        fifo_rst, pipe_in_ready, pipe_out_ready, engine_en, busy, done, proto_err;
  logic [15:0] blocks_in, blocks_out;

  pipe_flow_ctrl #(
    .BLOCK_WORDS (128),
    .IN_DEPTH    (1024),
    .CNT_W       (10),
    .RST_HOLD    (8),
    .RST_RECOVER (32),
    .BLK_W       (16)
  ) dut (
    .okClk          (okClk),
    .rst            (rst),
    .start          (start),
    .num_blocks     (num_blocks),
    .in_wr_count    (in_wr_count),
    .out_rd_count   (out_rd_count),
    .pi_write       (pi_write),
    .po_read        (po_read),
    .fifo_rst       (fifo_rst),
    .pipe_in_ready  (pipe_in_ready),
    .pipe_out_ready (pipe_out_ready),
    .engine_en      (engine_en),
    .busy           (busy),
    .done           (done),
    .blocks_in      (blocks_in),
    .blocks_out     (blocks_out),
    .proto_err      (proto_err)
  );

  always #5 okClk = ~okClk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: total words moved per direction, blocks derived by division.
  string  m_mode = "";
  longint m_win, m_wout;
  int     m_num, m_left;
  bit     m_err, e_pir, e_por;

  function automatic int sat_blk(input longint w);
    longint b;
    b = w / BW;
    return (b > BLK_MAX) ? BLK_MAX : int'(b);
  endfunction

  task automatic model_step();
    int bi, bo, part;
    bit run, mv;
    if (rst) begin
      m_mode = "HOLD"; m_left = RST_HOLD;
      m_win = 0; m_wout = 0; m_num = 0; m_err = 0;
      e_pir = 0; e_por = 0;
      return;
    end
    bi   = sat_blk(m_win);
    bo   = sat_blk(m_wout);
    part = (m_win % BW != 0) ? 1 : 0;
    run  = (m_mode == "RUN");
    mv   = run || (m_mode == "DRAIN");
    if (pi_write && (!run || bi == m_num)) m_err = 1;
    if (po_read && (!mv || out_rd_count == 0)) m_err = 1;
    e_pir = run && (int'(in_wr_count) <= ROOM_MAX) && (bi + part < m_num);
    e_por = mv && (int'(out_rd_count) >= BW) && (bo < m_num);
    if (run && pi_write) m_win++;
    if (mv && po_read) m_wout++;
    if (m_mode == "HOLD") begin
      m_left--;
      if (m_left == 0) begin m_mode = "RECOV"; m_left = RST_RECOVER; end
    end else if (m_mode == "RECOV") begin
      m_left--;
      if (m_left == 0) m_mode = "IDLE";
    end else if (m_mode == "IDLE" || m_mode == "DONE") begin
      if (start) begin
        m_num = int'(num_blocks); m_win = 0; m_wout = 0;
        m_mode = (m_num == 0) ? "DONE" : "RUN";
      end
    end else if (run) begin
      if (bi == m_num) m_mode = "DRAIN";
    end else if (m_mode == "DRAIN") begin
      if (bo == m_num) m_mode = "DONE";
    end
  endtask

  task automatic cycle();
    logic [38:0] got, exp;
    bit eb;
    model_step();
    @(posedge okClk);
    #1;
    eb  = (m_mode == "RUN") || (m_mode == "DRAIN");
    exp = {m_mode == "HOLD", e_pir, e_por, eb, eb, m_mode == "DONE", m_err,
           16'(sat_blk(m_win)), 16'(sat_blk(m_wout))};
    got = {fifo_rst, pipe_in_ready, pipe_out_ready, engine_en, busy, done, proto_err,
           blocks_in, blocks_out};
    chk("cycle", 64'(got), 64'(exp));
  endtask

  task automatic do_reset();
    int hi;
    bit rdy;
    rst = 1; start = 0; pi_write = 0; po_read = 0;
    cycle();
    rst = 0;
    chk("rst_fifo_rst", 64'(fifo_rst), 64'd1);
    chk("rst_busy", 64'({busy, done, engine_en}), 64'd0);
    chk("rst_blocks", 64'({blocks_in, blocks_out}), 64'd0);
    chk("rst_err", 64'(proto_err), 64'd0);
    hi  = int'(fifo_rst);
    rdy = 0;
    repeat (RST_HOLD + RST_RECOVER) begin
      cycle();
      hi  += int'(fifo_rst);
      rdy |= pipe_in_ready | pipe_out_ready;
    end
    chk("fifo_rst_len", 64'(hi), 64'(RST_HOLD));
    chk("recov_ready", 64'(rdy), 64'd0);
    chk("idle_out", 64'({busy, done, engine_en, fifo_rst}), 64'd0);
  endtask

  task automatic rand_run();
    bit run, mv;
    num_blocks = 16'($urandom_range(1, 4));
    start = 1;
    cycle();
    start = 0;
    for (int c = 0; c < 4000 && m_mode != "DONE"; c++) begin
      in_wr_count  = ($urandom % 4 == 0) ? 10'($urandom) : 10'($urandom_range(880, 912));
      out_rd_count = 10'($urandom_range(0, 260));
      run = (m_mode == "RUN");
      mv  = run || (m_mode == "DRAIN");
      pi_write = (run && m_win < longint'(m_num) * BW && $urandom % 3 != 0) || ($urandom % 400 == 0);
      po_read  = (mv && m_wout < m_win && out_rd_count != 0 && $urandom % 2 == 1) || ($urandom % 400 == 0);
      start      = ($urandom % 150 == 0);
      num_blocks = 16'($urandom_range(0, 3));
      cycle();
    end
    start = 0; pi_write = 0; po_read = 0;
    cycle();
  endtask

  initial begin
    bit eng;
    rst = 1; start = 0; pi_write = 0; po_read = 0;
    num_blocks = '0; in_wr_count = '0; out_rd_count = '0;

    do_reset();

    // single block in and out
    num_blocks = 16'd1; start = 1;
    cycle();
    start = 0;
    cycle();
    chk("single_pin_rdy", 64'(pipe_in_ready), 64'd1);
    pi_write = 1;
    repeat (BW) cycle();
    pi_write = 0;
    chk("single_blocks_in", 64'(blocks_in), 64'd1);
    cycle();
    chk("single_drain", 64'({pipe_in_ready, busy, done}), 64'b010);
    out_rd_count = 10'd128;
    cycle();
    chk("single_pout_rdy", 64'(pipe_out_ready), 64'd1);
    po_read = 1;
    repeat (BW) cycle();
    po_read = 0;
    chk("single_blocks_out", 64'(blocks_out), 64'd1);
    cycle();
    chk("single_done", 64'({done, busy}), 64'b10);

    // occupancy throttling at the thresholds
    in_wr_count = 10'd897; out_rd_count = 10'd0;
    num_blocks = 16'd4; start = 1;
    cycle();
    start = 0;
    cycle();
    chk("thr_in_897", 64'(pipe_in_ready), 64'd0);
    in_wr_count = 10'd896;
    cycle();
    chk("thr_in_896", 64'(pipe_in_ready), 64'd1);
    out_rd_count = 10'd127;
    cycle();
    chk("thr_out_127", 64'(pipe_out_ready), 64'd0);
    out_rd_count = 10'd128;
    cycle();
    chk("thr_out_128", 64'(pipe_out_ready), 64'd1);

    do_reset();

    // zero-block run
    num_blocks = 16'd0; start = 1;
    cycle();
    start = 0;
    chk("zero_done", 64'({done, busy, engine_en}), 64'b100);
    eng = 0;
    repeat (10) begin cycle(); eng |= engine_en; end
    chk("zero_engine", 64'(eng), 64'd0);

    // protocol error is sticky across a new start
    pi_write = 1;
    cycle();
    pi_write = 0;
    chk("err_set", 64'(proto_err), 64'd1);
    num_blocks = 16'd1; start = 1;
    cycle();
    start = 0;
    cycle();
    chk("err_sticky", 64'({proto_err, busy}), 64'b11);

    do_reset();

    // reset in the middle of a run
    in_wr_count = '0; out_rd_count = '0;
    num_blocks = 16'd5; start = 1;
    cycle();
    start = 0;
    pi_write = 1;
    repeat (3 * BW) cycle();
    pi_write = 0;
    out_rd_count = 10'd128;
    po_read = 1;
    repeat (BW) cycle();
    po_read = 0;
    chk("mid_counts", 64'({blocks_in, blocks_out}), 64'({16'd3, 16'd1}));
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset();

    for (int r = 0; r < 6; r++) begin
      if ($urandom % 2 == 0) do_reset();
      rand_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Transfer scheduler for the BT-pipe FIFO datapath: pipe-in FIFO (32-bit write, 256-bit read) → pattern engine → pipe-out FIFO (64-bit write, 32-bit read).
- Sequences FIFO reset and recovery after host reset, then arms a run of a host-specified number of blocks.
- Throttles okBTPipeIn/okBTPipeOut block-ready flags from the FIFO occupancy counts.
- Gates the pattern engine enable; counts completed blocks in each direction; flags protocol errors.
- Sits beside the FIFOs in the top level, all on okClk.

Parameters:
BLOCK_WORDS, 128, 32-bit words per BT block (power of two)
IN_DEPTH, 1024, pipe-in FIFO depth in 32-bit write words
CNT_W, 10, width of FIFO occupancy count inputs
RST_HOLD, 8, cycles fifo_rst held high
RST_RECOVER, 32, cycles after fifo_rst falls before any ready may assert
BLK_W, 16, width of block counters and num_blocks

Ports:
okClk  in  1  sole clock
rst  in  1  synchronous active-high reset (host wire-in)
start  in  1  single-cycle pulse; arms a run
num_blocks  in  BLK_W  blocks to move in each direction; sampled on accepted start
in_wr_count  in  CNT_W  pipe-in FIFO write-side data count
out_rd_count  in  CNT_W  pipe-out FIFO read-side data count
pi_write  in  1  okBTPipeIn ep_write (one 32-bit word)
po_read  in  1  okBTPipeOut ep_read (one 32-bit word)
fifo_rst  out  1  reset to both FIFOs and the pattern engine
pipe_in_ready  out  1  okBTPipeIn ep_ready
pipe_out_ready  out  1  okBTPipeOut ep_ready
engine_en  out  1  pattern engine stream enable
busy  out  1  high in RUN or DRAIN
done  out  1  level; high in DONE
blocks_in  out  BLK_W  completed input blocks this run
blocks_out  out  BLK_W  completed output blocks this run
proto_err  out  1  sticky protocol error

Behaviour:
- State register: S_HOLD, S_RECOV, S_IDLE, S_RUN, S_DRAIN, S_DONE. All outputs are registered.
- rst (any state, including mid-run) → S_HOLD next cycle.
  - Clears counters, word counters, proto_err and the latched num_blocks.
  - fifo_rst=1; all other outputs 0.
- S_HOLD: fifo_rst=1 for exactly RST_HOLD cycles, then → S_RECOV.
- S_RECOV: fifo_rst=0; readies held 0 for RST_RECOVER cycles, then → S_IDLE.
- S_IDLE/S_DONE, start=1:
  - Latch num_blocks; clear blocks_in, blocks_out and the word counters.
  - Next state is S_RUN, or S_DONE if num_blocks==0.
  - start is ignored in every other state.
- S_RUN → S_DRAIN when blocks_in == latched num_blocks.
- S_DRAIN → S_DONE when blocks_out == latched num_blocks.
- Both transitions are evaluated on the registered counter value, so they occur one cycle after the final word.
- engine_en=1 in S_RUN and S_DRAIN.
- pipe_in_ready, next cycle = 1 iff all of:
  - state S_RUN;
  - in_wr_count ≤ IN_DEPTH−BLOCK_WORDS;
  - blocks_in + (in_word_cnt≠0) < latched num_blocks.
- pipe_out_ready, next cycle = 1 iff all of:
  - state S_RUN or S_DRAIN;
  - out_rd_count ≥ BLOCK_WORDS;
  - blocks_out < latched num_blocks.
- Readies have 1-cycle latency from the count inputs. Deassertion mid-block is allowed; the host only samples ready at block boundaries.
- Word counters are log2(BLOCK_WORDS) bits and increment on pi_write / po_read.
  - On wrap (BLOCK_WORDS−1 → 0) the matching block counter increments.
  - Block counters saturate at 2^BLK_W−1.
- pi_write and po_read in the same cycle are independent; both are counted.
- proto_err sets (sticky until rst) on any of:
  - pi_write outside S_RUN;
  - po_read outside S_RUN/S_DRAIN;
  - po_read with out_rd_count==0;
  - pi_write with blocks_in == latched num_blocks.
- An erroring word is still counted if the state allows counting.

Decomposition:
- Shared package holds:
  - the state enumeration (3-bit encoding);
  - the BLOCK_WORDS/IN_DEPTH defaults;
  - the word-counter width function clog2.
- One natural sub-module: pipe_blk_counter (word counter + saturating block counter, wrap pulse). Instantiate it twice, for the in and out directions.

Test Plan:
- Reset sequencing: pulse rst 1 cycle → fifo_rst high 8 cycles, low with readies 0 for 32 more cycles, then state IDLE with all counters 0.
- Single block: start with num_blocks=1, in_wr_count=0 → pipe_in_ready=1 next cycle. After 128 pi_write: blocks_in=1, pipe_in_ready=0, state DRAIN. With out_rd_count=128, 128 po_read → blocks_out=1, done=1.
- Throttle: in S_RUN, drive in_wr_count=897 → pipe_in_ready=0 next cycle; drive 896 → 1 next cycle. Drive out_rd_count=127 → pipe_out_ready=0.
- Zero blocks: start with num_blocks=0 → DONE next cycle, engine_en never asserts.
- Protocol error: pi_write while IDLE → proto_err=1; it stays 1 across a new start and clears only on rst.
- Mid-run reset: rst after 3 blocks in, 1 out of 5 → fifo_rst=1 next cycle, blocks_in=blocks_out=0, busy=0; the full HOLD/RECOV sequence repeats.
